// File: rtl/rt_i2c_pkg.sv
// Shared constants and the state encoding for the I2C target.
package rt_i2c_pkg;

  localparam int ADDR_W = 7;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] RD_IDLE_FILL = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT_STOP
  } state_t;

endpackage

// File: rtl/rt_i2c_filter.sv
// Two-flop synchronizer followed by a stable-sample filter for one bus line.
// Rise/fall strobes are registered together with the filtered line.
module rt_i2c_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_line,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_line;
  logic             r_rise;
  logic             r_fall;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others, whatever the statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= 2'b11;
      r_cnt  <= '0;
      r_line <= 1'b1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_pin};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_sync[1] != r_line) begin
        // The FILTER_LEN-th consecutive differing sample commits the change.
        if (r_cnt == CNT_W'(FILTER_LEN - 1)) begin
          r_line <= r_sync[1];
          r_cnt  <= '0;
          r_rise <= r_sync[1];
          r_fall <= ~r_sync[1];
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_line = r_line;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/rt_i2c_target.sv
// I2C target: filtered SCL/SDA, START/STOP detection, address match and
// byte-wide write/read handshakes toward the user side.
module rt_i2c_target
  import rt_i2c_pkg::*;
#(
  parameter int FILTER_LEN = 3
) (
  input  logic              rt_i_clk,
  input  logic              rt_i_rst,
  input  logic              rt_i_scl,
  input  logic              rt_i_sda,
  input  logic [ADDR_W-1:0] rt_i_addr,
  input  logic              rt_i_rx_ready,
  input  logic [BYTE_W-1:0] rt_i_tx_data,
  input  logic              rt_i_tx_valid,
  output logic              rt_o_sda_oe,
  output logic [BYTE_W-1:0] rt_o_rx_data,
  output logic              rt_o_rx_valid,
  output logic              rt_o_tx_ready,
  output logic              rt_o_rw,
  output logic              rt_o_busy,
  output logic              rt_o_start,
  output logic              rt_o_stop,
  output logic              rt_o_nak
);

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;

  rt_i2c_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .i_clk  (rt_i_clk),
    .i_rst  (rt_i_rst),
    .i_pin  (rt_i_scl),
    .o_line (w_scl),
    .o_rise (w_scl_rise),
    .o_fall (w_scl_fall)
  );

  rt_i2c_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .i_clk  (rt_i_clk),
    .i_rst  (rt_i_rst),
    .i_pin  (rt_i_sda),
    .o_line (w_sda),
    .o_rise (w_sda_rise),
    .o_fall (w_sda_fall)
  );

  logic w_start, w_stop;
  assign w_start = w_sda_fall & w_scl;
  assign w_stop  = w_sda_rise & w_scl;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic [BYTE_W-1:0] r_shift, w_shift_nxt;
  logic              r_sda_oe, w_sda_oe_nxt;
  logic              r_rw, w_rw_nxt;
  logic              r_busy, w_busy_nxt;
  logic [BYTE_W-1:0] r_rx_data, w_rx_data_nxt;
  logic              r_rx_valid, w_rx_valid_nxt;
  logic              r_tx_ready, w_tx_ready_nxt;
  logic              r_nak, w_nak_nxt;

  logic [BYTE_W-1:0] w_rx_byte;
  logic [BYTE_W-1:0] w_load_byte;
  assign w_rx_byte   = {r_shift[BYTE_W-2:0], w_sda};
  assign w_load_byte = rt_i_tx_valid ? rt_i_tx_data : RD_IDLE_FILL;

  always_ff @(posedge rt_i_clk) begin
    if (rt_i_rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_sda_oe   <= 1'b0;
      r_rw       <= 1'b0;
      r_busy     <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_tx_ready <= 1'b0;
      r_nak      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
      r_rw       <= w_rw_nxt;
      r_busy     <= w_busy_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_tx_ready <= w_tx_ready_nxt;
      r_nak      <= w_nak_nxt;
    end
  end

  // NOTE: every output of this block is given a default before the case so
  // no path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_shift_nxt    = r_shift;
    w_sda_oe_nxt   = r_sda_oe;
    w_rw_nxt       = r_rw;
    w_busy_nxt     = r_busy;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_tx_ready_nxt = 1'b0;
    w_nak_nxt      = 1'b0;

    if (w_start) begin
      w_state_nxt  = ST_ADDR;
      w_cnt_nxt    = '0;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else if (w_stop) begin
      w_state_nxt  = ST_IDLE;
      w_cnt_nxt    = '0;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_rx_byte;
            w_cnt_nxt   = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              w_cnt_nxt = '0;
              if (w_rx_byte[BYTE_W-1:1] == rt_i_addr) begin
                w_rw_nxt    = w_rx_byte[0];
                w_busy_nxt  = 1'b1;
                w_state_nxt = ST_ADDR_ACK;
              end else begin
                w_state_nxt = ST_WAIT_STOP;
              end
            end
          end
        end

        ST_ADDR_ACK: begin
          if (w_scl_fall) begin
            if (!r_sda_oe) begin
              w_sda_oe_nxt = 1'b1;
            end else if (r_rw) begin
              // Shift register holds the remaining bits, MSB-aligned.
              w_shift_nxt    = {w_load_byte[BYTE_W-2:0], 1'b1};
              w_sda_oe_nxt   = ~w_load_byte[BYTE_W-1];
              w_cnt_nxt      = 4'd1;
              w_tx_ready_nxt = rt_i_tx_valid;
              w_state_nxt    = ST_RD_DATA;
            end else begin
              w_sda_oe_nxt = 1'b0;
              w_state_nxt  = ST_WR_DATA;
            end
          end
        end

        ST_WR_DATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_rx_byte;
            w_cnt_nxt   = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              w_cnt_nxt      = '0;
              w_rx_data_nxt  = w_rx_byte;
              w_rx_valid_nxt = 1'b1;
              w_state_nxt    = ST_WR_ACK;
            end
          end
        end

        ST_WR_ACK: begin
          // The user's ready is judged in the same cycle as the rx strobe.
          if (r_rx_valid) begin
            if (!rt_i_rx_ready) begin
              w_state_nxt = ST_WAIT_STOP;
            end
          end else if (w_scl_fall) begin
            if (!r_sda_oe) begin
              w_sda_oe_nxt = 1'b1;
            end else begin
              w_sda_oe_nxt = 1'b0;
              w_state_nxt  = ST_WR_DATA;
            end
          end
        end

        ST_RD_DATA: begin
          if (w_scl_fall) begin
            if (r_cnt == 4'd8) begin
              w_sda_oe_nxt = 1'b0;
              w_cnt_nxt    = '0;
              w_state_nxt  = ST_RD_ACK;
            end else begin
              w_sda_oe_nxt = ~r_shift[BYTE_W-1];
              w_shift_nxt  = {r_shift[BYTE_W-2:0], 1'b1};
              w_cnt_nxt    = r_cnt + 4'd1;
            end
          end
        end

        ST_RD_ACK: begin
          if (w_scl_rise && w_sda) begin
            w_nak_nxt   = 1'b1;
            w_state_nxt = ST_WAIT_STOP;
          end else if (w_scl_fall) begin
            w_shift_nxt    = {w_load_byte[BYTE_W-2:0], 1'b1};
            w_sda_oe_nxt   = ~w_load_byte[BYTE_W-1];
            w_cnt_nxt      = 4'd1;
            w_tx_ready_nxt = rt_i_tx_valid;
            w_state_nxt    = ST_RD_DATA;
          end
        end

        default: begin
          w_sda_oe_nxt = 1'b0;
        end
      endcase
    end
  end

  assign rt_o_sda_oe   = r_sda_oe;
  assign rt_o_rx_data  = r_rx_data;
  assign rt_o_rx_valid = r_rx_valid;
  assign rt_o_tx_ready = r_tx_ready;
  assign rt_o_rw       = r_rw;
  assign rt_o_busy     = r_busy;
  assign rt_o_start    = w_start;
  assign rt_o_stop     = w_stop;
  assign rt_o_nak      = r_nak;

endmodule

// File: tb/tb_rt_i2c_target.sv
// Directed I2C controller model with an event scoreboard for the target's
// strobes and direct checks of bus-level ACK/data bits.
module tb_rt_i2c_target;

  localparam int Q = 10;

  typedef enum logic [2:0] {EV_START, EV_STOP, EV_RX, EV_TXRDY, EV_NAK} ev_kind_e;
  typedef struct packed {
    ev_kind_e    kind;
    logic [7:0]  data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic [6:0] addr = 7'h50;
  logic       rx_ready = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;

  logic       sda_oe, rx_valid, tx_ready, rw, busy, start_p, stop_p, nak_p;
  logic [7:0] rx_data;
  wire        w_bus_sda = m_sda & ~sda_oe;

  int n_checks = 0;
  int n_errors = 0;
  int oe_cycles = 0;
  int busy_cycles = 0;
  ev_t exp_q[$];

  rt_i2c_target #(.FILTER_LEN(3)) dut (
    .rt_i_clk      (clk),
    .rt_i_rst      (rst),
    .rt_i_scl      (m_scl),
    .rt_i_sda      (w_bus_sda),
    .rt_i_addr     (addr),
    .rt_i_rx_ready (rx_ready),
    .rt_i_tx_data  (tx_data),
    .rt_i_tx_valid (tx_valid),
    .rt_o_sda_oe   (sda_oe),
    .rt_o_rx_data  (rx_data),
    .rt_o_rx_valid (rx_valid),
    .rt_o_tx_ready (tx_ready),
    .rt_o_rw       (rw),
    .rt_o_busy     (busy),
    .rt_o_start    (start_p),
    .rt_o_stop     (stop_p),
    .rt_o_nak      (nak_p)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input ev_kind_e k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic mon_ev(input ev_kind_e k, input logic [7:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_event: got kind=%0d data=%0h, expected none", k, d);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(k), 32'(e.kind));
      if (k == EV_RX) check("rx_data", 32'(d), 32'(e.data));
    end
  endtask

  // Monitor: one strobe sample per cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (start_p)  mon_ev(EV_START, 8'h00);
        if (rx_valid) mon_ev(EV_RX, rx_data);
        if (tx_ready) mon_ev(EV_TXRDY, 8'h00);
        if (nak_p)    mon_ev(EV_NAK, 8'h00);
        if (stop_p)   mon_ev(EV_STOP, 8'h00);
        if (sda_oe)   oe_cycles++;
        if (busy)     busy_cycles++;
      end
    end
  end

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wq(Q);
    m_scl = 1'b1; wq(Q);
    m_sda = 1'b0; wq(Q);
    m_scl = 1'b0; wq(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wq(Q);
    m_scl = 1'b1; wq(Q);
    m_sda = 1'b1; wq(2 * Q);
  endtask

  task automatic bus_bit(input logic b, output logic s);
    m_sda = b;    wq(Q);
    m_scl = 1'b1; wq(Q);
    s = w_bus_sda; wq(Q);
    m_scl = 1'b0; wq(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
    bus_bit(1'b1, ack);
  endtask

  task automatic rd_byte(input logic ack_bit, input logic [7:0] nxt, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bus_bit(1'b1, s);
      d = {d[6:0], s};
    end
    tx_data = nxt;
    bus_bit(ack_bit, s);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         oe0, busy0;

    repeat (4) @(negedge clk);
    rst = 1'b0;
    wq(2);
    check("reset_sda_oe", 32'(sda_oe), 0);
    check("reset_rx_data", 32'(rx_data), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_rw", 32'(rw), 0);
    wq(20);

    // Write 0x3C to own address.
    push_ev(EV_START, 8'h00); push_ev(EV_RX, 8'h3C); push_ev(EV_STOP, 8'h00);
    bus_start();
    wr_byte(8'hA0, ack); check("wr_addr_ack", 32'(ack), 0);
    check("wr_busy", 32'(busy), 1);
    check("wr_rw", 32'(rw), 0);
    wr_byte(8'h3C, ack); check("wr_data_ack", 32'(ack), 0);
    bus_stop();
    check("wr_busy_after_stop", 32'(busy), 0);

    // Foreign address: target must stay silent.
    oe0 = oe_cycles; busy0 = busy_cycles;
    push_ev(EV_START, 8'h00); push_ev(EV_STOP, 8'h00);
    bus_start();
    wr_byte(8'hA2, ack); check("miss_addr_ack", 32'(ack), 1);
    wr_byte(8'h11, ack); check("miss_data_ack", 32'(ack), 1);
    bus_stop();
    check("miss_oe_cycles", 32'(oe_cycles - oe0), 0);
    check("miss_busy_cycles", 32'(busy_cycles - busy0), 0);

    // Read two bytes, ACK then NAK.
    tx_valid = 1'b1; tx_data = 8'h5A;
    push_ev(EV_START, 8'h00); push_ev(EV_TXRDY, 8'h00); push_ev(EV_TXRDY, 8'h00);
    push_ev(EV_NAK, 8'h00); push_ev(EV_STOP, 8'h00);
    bus_start();
    wr_byte(8'hA1, ack); check("rd_addr_ack", 32'(ack), 0);
    check("rd_rw", 32'(rw), 1);
    rd_byte(1'b0, 8'hC3, d); check("rd_byte0", 32'(d), 32'h5A);
    rd_byte(1'b1, 8'h00, d); check("rd_byte1", 32'(d), 32'hC3);
    bus_stop();

    // Read with no data available: idle fill, no tx_ready.
    tx_valid = 1'b0;
    push_ev(EV_START, 8'h00); push_ev(EV_NAK, 8'h00); push_ev(EV_STOP, 8'h00);
    bus_start();
    wr_byte(8'hA1, ack); check("fill_addr_ack", 32'(ack), 0);
    rd_byte(1'b1, 8'h00, d); check("fill_byte", 32'(d), 32'hFF);
    bus_stop();

    // Write refused by the user: NAK and ignore the rest.
    rx_ready = 1'b0;
    push_ev(EV_START, 8'h00); push_ev(EV_RX, 8'h77); push_ev(EV_STOP, 8'h00);
    bus_start();
    wr_byte(8'hA0, ack); check("nak_addr_ack", 32'(ack), 0);
    wr_byte(8'h77, ack); check("nak_data_ack", 32'(ack), 1);
    wr_byte(8'h12, ack); check("nak_extra_ack", 32'(ack), 1);
    bus_stop();
    check("nak_rx_data_held", 32'(rx_data), 32'h77);
    rx_ready = 1'b1;

    // Reset while driving a 0 bit, then no response without a fresh START.
    tx_valid = 1'b1; tx_data = 8'h00;
    push_ev(EV_START, 8'h00); push_ev(EV_TXRDY, 8'h00);
    bus_start();
    wr_byte(8'hA1, ack); check("rst_addr_ack", 32'(ack), 0);
    check("rst_driving_zero", 32'(sda_oe), 1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rst_sda_oe", 32'(sda_oe), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_rw", 32'(rw), 0);
    check("rst_busy", 32'(busy), 0);
    @(negedge clk); rst = 1'b0;
    wq(Q);
    wr_byte(8'hA0, ack); check("rst_no_start_ack", 32'(ack), 1);
    push_ev(EV_STOP, 8'h00);
    bus_stop();

    // Repeated START in the middle of a write byte.
    push_ev(EV_START, 8'h00);
    bus_start();
    wr_byte(8'hA0, ack); check("rs_addr_ack", 32'(ack), 0);
    bus_bit(1'b0, ack); bus_bit(1'b0, ack); bus_bit(1'b1, ack); bus_bit(1'b1, ack);
    tx_data = 8'h81;
    push_ev(EV_START, 8'h00); push_ev(EV_TXRDY, 8'h00);
    push_ev(EV_NAK, 8'h00); push_ev(EV_STOP, 8'h00);
    bus_start();
    check("rs_sda_oe", 32'(sda_oe), 0);
    wr_byte(8'hA1, ack); check("rs_rd_addr_ack", 32'(ack), 0);
    check("rs_rw", 32'(rw), 1);
    rd_byte(1'b1, 8'h00, d); check("rs_rd_byte", 32'(d), 32'h81);
    bus_stop();

    wq(20);
    check("events_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rt_i2c_target.md
RT_I2C_TARGET -- requirements
Module: rt_i2c_target

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 3, the number of consecutive equal synchronized samples required before filtered SCL/SDA change.
REQ-002 SHALL have these ports:
- rt_i_clk  input  1  sole clock; all logic rising-edge.
- rt_i_rst  input  1  synchronous, active-high reset.
- rt_i_scl  input  1  raw bus SCL, asynchronous.
- rt_i_sda  input  1  raw bus SDA, asynchronous.
- rt_i_addr  input  7  own 7-bit target address, quasi-static.
- rt_i_rx_ready  input  1  user can accept a write byte.
- rt_i_tx_data  input  8  next read byte.
- rt_i_tx_valid  input  1  rt_i_tx_data is valid.
- rt_o_sda_oe  output  1  1 = pull SDA low; 0 = release.
- rt_o_rx_data  output  8  received write byte.
- rt_o_rx_valid  output  1  1-cycle strobe: rt_o_rx_data is new.
- rt_o_tx_ready  output  1  1-cycle strobe: read byte is loaded this cycle.
- rt_o_rw  output  1  R/W bit of the last matched address (1 = read).
- rt_o_busy  output  1  addressed transaction in progress.
- rt_o_start  output  1  1-cycle strobe on START or repeated START.
- rt_o_stop  output  1  1-cycle strobe on STOP.
- rt_o_nak  output  1  1-cycle strobe when the controller NAKs a read byte.

Function
REQ-003 SHALL pass each pin through a 2-flop synchronizer and then a FILTER_LEN stable-sample filter; filtered lines reset to 1.
REQ-004 SHALL detect START when filtered SDA falls while filtered SCL is high, and STOP when filtered SDA rises while filtered SCL is high; SCL edges are filtered-SCL transitions.
REQ-005 SHALL sample SDA only on SCL rising edges and change rt_o_sda_oe only on SCL falling edges, except on START/STOP/reset.
REQ-006 SHALL implement states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
REQ-007 On START from any state: enter ADDR, clear bit count, rt_o_sda_oe=0, pulse rt_o_start.
REQ-008 On STOP from any state: enter IDLE, rt_o_sda_oe=0, rt_o_busy=0, pulse rt_o_stop.
REQ-009 In ADDR, shift 8 bits MSB first; on the 8th rising edge, a match of bits[7:1] to rt_i_addr latches rt_o_rw=bit0, sets rt_o_busy, and enters ADDR_ACK; a mismatch enters WAIT_STOP and never drives SDA.
REQ-010 ADDR_ACK: assert rt_o_sda_oe at the next falling edge and release it at the following falling edge; then enter WR_DATA if rw=0, or RD_DATA if rw=1.
REQ-011 WR_DATA: on the 8th rising edge, update rt_o_rx_data and pulse rt_o_rx_valid for one cycle; rt_i_rx_ready sampled in that cycle selects ACK (WR_ACK drives low for one SCL low-high-low period). Otherwise NAK: SDA stays released, the byte is dropped, and the state becomes WAIT_STOP.
REQ-012 RD_DATA entry (falling edge ending ACK): load the shift register from rt_i_tx_data if rt_i_tx_valid, else 8'hFF; pulse rt_o_tx_ready only when rt_i_tx_valid=1.
REQ-013 RD_DATA: drive rt_o_sda_oe = ~bit, MSB first, each bit set at a falling edge; after the 8th bit's falling edge, release SDA and enter RD_ACK.
REQ-014 RD_ACK: on the 9th rising edge, SDA=0 continues to RD_DATA; SDA=1 pulses rt_o_nak and enters WAIT_STOP.
REQ-015 WAIT_STOP and IDLE SHALL ignore SCL edges, keep SDA released, and leave only on START/STOP.
REQ-016 Strobes SHALL be exactly one cycle; START/STOP detection latency SHALL be 2+FILTER_LEN clocks after the pin edge.
REQ-017 A simultaneous START and SCL edge SHALL resolve to START.

Reset
REQ-018 rt_i_rst SHALL force IDLE, filtered lines=1, bit count=0, and all outputs 0 (rt_o_rx_data=8'h00) on the next clock edge, including mid-transfer.
REQ-019 After reset, the block SHALL require a fresh START before responding.

Structure
REQ-020 Package rt_i2c_pkg SHALL hold the state encoding, address width (7), byte width (8), and the read-idle fill 8'hFF.
REQ-021 Sub-module rt_i2c_filter (synchronizer plus FILTER_LEN filter) SHALL be instantiated once for SCL and once for SDA.

Verification
REQ-022 rt_i_addr=7'h50, write 0xA0,0x3C,STOP, rx_ready=1 -> ACK on both bytes, one rx_valid with rx_data=8'h3C, rw=0, stop pulse.
REQ-023 Address 0xA2 with rt_i_addr=7'h50 -> SDA never driven, no rx_valid, busy stays 0 until STOP.
REQ-024 Read 0xA1, tx_valid=1 with 8'h5A then 8'hC3, controller ACK then NAK -> bus bits 01011010, 11000011, two tx_ready pulses, one nak pulse.
REQ-025 Read with tx_valid=0 -> bus byte 8'hFF, no tx_ready.
REQ-026 Write with rx_ready=0 at byte 1 -> rx_valid pulse, NAK on bus, remaining bytes ignored until STOP.
REQ-027 Reset asserted mid-RD_DATA while driving 0, and separately a repeated START mid-write -> sda_oe=0 next clock; START returns to ADDR with a start pulse.
